serial_sub: RTL and testbench



---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/full_sub.sv | 26 ++
 rtl/serial_sub.sv | 147 ++++++++++++++
 tb/tb_serial_sub.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared state encodings and default width for the bit-serial subtractor.
// Imported by serial_sub and full_sub.
package serial_sub_pkg;

  typedef enum logic {
    SS_IDLE  = 1'b0,
    SS_SHIFT = 1'b1
  } ss_state_e;

  localparam int SS_WIDTH_DEF = 8;

endpackage

// File: rtl/full_sub.sv
// 1-bit full subtractor: two half-subtractor stages plus an OR.
// d = x ^ y ^ bi, bo = (~x & y) | (~(x ^ y) & bi).
module full_sub
  import serial_sub_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  logic d1;
  logic b1;
  logic b2;

  // first half stage x - y, second half stage (x - y) - bi
  always_comb begin
    d1 = x ^ y;
    b1 = ~x & y;
    d  = d1 ^ bi;
    b2 = ~d1 & bi;
    bo = b1 | b2;
  end

endmodule

// File: rtl/serial_sub.sv
// Bit-serial a - b, LSB first, one bit per clock, start/done handshake.
// Optional signed overflow port enabled by SERIAL_SUB_OVERFLOW_EN.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SS_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  ss_state_e        state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             bq_q, bq_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             done_q, done_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             amsb_q, amsb_d;
  logic             bmsb_q, bmsb_d;
  logic             ovf_q, ovf_d;
`endif

  logic bit_d;
  logic bit_bo;

  full_sub u_fs (
    .x  (sa_q[0]),
    .y  (sb_q[0]),
    .bi (bq_q),
    .d  (bit_d),
    .bo (bit_bo)
  );

  // next-state and datapath: load in IDLE, one bit step per SHIFT edge
  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sr_d     = sr_q;
    bq_d     = bq_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    done_d   = 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
    amsb_d   = amsb_q;
    bmsb_d   = bmsb_q;
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      SS_IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          bq_d    = 1'b0;
          cnt_d   = '0;
          state_d = SS_SHIFT;
`ifdef SERIAL_SUB_OVERFLOW_EN
          amsb_d  = a[WIDTH-1];
          bmsb_d  = b[WIDTH-1];
`endif
        end
      end
      SS_SHIFT: begin
        sa_d  = {1'b0, sa_q[WIDTH-1:1]};
        sb_d  = {1'b0, sb_q[WIDTH-1:1]};
        sr_d  = {bit_d, sr_q[WIDTH-1:1]};
        bq_d  = bit_bo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          diff_d   = {bit_d, sr_q[WIDTH-1:1]};
          borrow_d = bit_bo;
          done_d   = 1'b1;
          state_d  = SS_IDLE;
`ifdef SERIAL_SUB_OVERFLOW_EN
          ovf_d    = (amsb_q != bmsb_q) && (bit_d != amsb_q);
`endif
        end
      end
      default: state_d = SS_IDLE;
    endcase
  end

  // state and datapath registers, all cleared by async reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= SS_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sr_q     <= '0;
      bq_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      amsb_q   <= 1'b0;
      bmsb_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sr_q     <= sr_d;
      bq_q     <= bq_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      done_q   <= done_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
      amsb_q   <= amsb_d;
      bmsb_q   <= bmsb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  // outputs come straight from registers
  always_comb begin
    busy   = (state_q == SS_SHIFT);
    done   = done_q;
    diff   = diff_q;
    borrow = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    overflow = ovf_q;
`endif
  end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: vector table plus corner sequences.
// Overflow checks compile in when SERIAL_SUB_OVERFLOW_EN is defined.
module tb_serial_sub;
  import serial_sub_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic         overflow;
`endif

  serial_sub #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
`ifdef SERIAL_SUB_OVERFLOW_EN
    .overflow (overflow),
`endif
    .borrow   (borrow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] d;
    logic         br;
    logic         ov;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    res_t         r;
  } vec_t;

  res_t         sb[$];
  res_t         mon_e;
  int           total = 0;
  int           bad = 0;
  int           dones = 0;
  int           pushes = 0;
  logic [W-1:0] last_diff = '0;
  vec_t         tbl[10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // scoreboard: each done pulse pops the oldest expected result
  always @(negedge clk) begin
    if (done) begin
      dones++;
      if (sb.size() == 0) begin
        chk("done_count", dones, pushes);
      end else begin
        mon_e = sb.pop_front();
        chk("diff", {24'd0, diff}, {24'd0, mon_e.d});
        chk("borrow", {31'd0, borrow}, {31'd0, mon_e.br});
`ifdef SERIAL_SUB_OVERFLOW_EN
        chk("overflow", {31'd0, overflow}, {31'd0, mon_e.ov});
`endif
      end
    end
  end

  task automatic op_start(input logic [W-1:0] x, input logic [W-1:0] y,
                          input res_t e, input bit push);
    a = x;
    b = y;
    start = 1'b1;
    if (push) begin
      sb.push_back(e);
      pushes++;
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input logic [W-1:0] held);
    int cyc;
    bit got;
    cyc = 0;
    got = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
      if (k == 0) begin
        chk("busy", {31'd0, busy}, 32'd1);
        chk("held_diff", {24'd0, diff}, {24'd0, held});
      end
      @(posedge clk);
      cyc++;
    end
    chk("done_seen", {31'd0, got}, 32'd1);
    chk("latency", cyc, W);
  endtask

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                       input res_t e);
    op_start(x, y, e, 1'b1);
    wait_done(last_diff);
    last_diff = e.d;
  endtask

  initial begin
    int   cyc;
    bit   got;
    res_t e;

    tbl[0] = '{8'h35, 8'h12, '{8'h23, 1'b0, 1'b0}};
    tbl[1] = '{8'h12, 8'h35, '{8'hDD, 1'b1, 1'b0}};
    tbl[2] = '{8'h80, 8'h01, '{8'h7F, 1'b0, 1'b1}};
    tbl[3] = '{8'h00, 8'h01, '{8'hFF, 1'b1, 1'b0}};
    tbl[4] = '{8'hFF, 8'hFF, '{8'h00, 1'b0, 1'b0}};
    tbl[5] = '{8'h7F, 8'hFF, '{8'h80, 1'b1, 1'b1}};
    tbl[6] = '{8'h00, 8'h80, '{8'h80, 1'b1, 1'b1}};
    tbl[7] = '{8'h80, 8'h7F, '{8'h01, 1'b0, 1'b1}};
    tbl[8] = '{8'h01, 8'h02, '{8'hFF, 1'b1, 1'b0}};
    tbl[9] = '{8'hC8, 8'h64, '{8'h64, 1'b0, 1'b1}};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_diff", {24'd0, diff}, 32'd0);
    chk("rst_borrow", {31'd0, borrow}, 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
`endif

    // back-to-back: each op is started in the previous done cycle
    for (int i = 0; i < 10; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].r);
    end
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_hold", {24'd0, diff}, {24'd0, last_diff});

    // inputs and start wiggle while busy; must not disturb the op
    e = '{8'h23, 1'b0, 1'b0};
    op_start(8'h35, 8'h12, e, 1'b1);
    cyc = 0;
    got = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
      if (k < 3) begin
        a = W'($urandom);
        b = W'($urandom);
        start = 1'b1;
        chk("busy_wiggle", {31'd0, busy}, 32'd1);
        chk("held_wiggle", {24'd0, diff}, {24'd0, last_diff});
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      cyc++;
    end
    chk("wiggle_done", {31'd0, got}, 32'd1);
    chk("wiggle_lat", cyc, W);
    last_diff = e.d;
    do_op(8'h00, 8'h01, '{8'hFF, 1'b1, 1'b0});

    // reset after the 4th bit edge discards the partial result
    @(negedge clk);
    op_start(8'h55, 8'h11, '{8'h44, 1'b0, 1'b0}, 1'b0);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_done", {31'd0, done}, 32'd0);
    chk("mid_diff", {24'd0, diff}, 32'd0);
    chk("mid_borrow", {31'd0, borrow}, 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("mid_ovf", {31'd0, overflow}, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    last_diff = '0;
    do_op(8'h0A, 8'h03, '{8'h07, 1'b0, 1'b0});

    @(negedge clk);
    chk("total_dones", dones, pushes);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
